// File: rtl/input_fifo_handshake.sv
// -----------------------------------------------------------------------------
// input_fifo_handshake
//
// Input-port buffer for one router port. It is the receiving end of the
// RTS/DCTS link driven by the neighbouring router's output arbiter. It accepts
// one flit per handshake (DRTS in, CTS out) into a small circular FIFO. It
// presents the head flit to the local crossbar and pops it when any local
// output arbiter grants it.
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous active-low reset
//   DRTS            upstream request-to-send (held until CTS seen)
//   CTS             registered clear-to-send, one-cycle pulse per accepted flit
//   Data_in         upstream flit, valid while DRTS high
//   read_en_N/E/W/S/L  pop requests from the five local arbiters
//   Data_out        head-of-FIFO flit (combinational read of the array)
//   empty / full    occupancy flags derived from the registered count
//   count           current occupancy
//   err_multi_read  sticky flag: two or more read_en_* seen in one cycle
// -----------------------------------------------------------------------------
module input_fifo_handshake #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DRTS,
  output logic                  CTS,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  err_multi_read
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_r;
  logic [PTR_WIDTH-1:0]  rd_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic                  cts_r;
  logic                  err_r;

  logic                  read_en_s;
  logic                  write_en_s;
  logic                  pop_s;
  logic                  multi_s;
  logic [2:0]            rd_sum_s;
  logic                  empty_s;
  logic                  full_s;

  // Occupancy flags come straight from the registered count, so a pop in the
  // same cycle cannot relieve full.
  assign empty_s = (count_r == CNT_WIDTH'(0));
  assign full_s  = (count_r == CNT_WIDTH'(DEPTH));

  // Handshake, pop and multi-grant decode for the current cycle.
  always_comb begin
    rd_sum_s   = 3'd0;
    read_en_s  = 1'b0;
    write_en_s = 1'b0;
    pop_s      = 1'b0;
    multi_s    = 1'b0;
    rd_sum_s   = {2'b00, read_en_N} + {2'b00, read_en_E} + {2'b00, read_en_W}
               + {2'b00, read_en_S} + {2'b00, read_en_L};
    read_en_s  = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    // A high CTS means the sender has not yet dropped DRTS for the flit just
    // taken; refusing that cycle prevents a duplicate capture.
    write_en_s = DRTS & ~cts_r & ~full_s;
    pop_s      = read_en_s & ~empty_s;
    if (rd_sum_s >= 3'd2) begin
      multi_s = 1'b1;
    end else begin
      multi_s = 1'b0;
    end
  end

  // Storage array: cleared on reset so Data_out never shows undefined content.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (write_en_s) begin
      mem_r[wr_ptr_r] <= Data_in;
    end
  end

  // Pointers, occupancy counter, CTS pulse and sticky multi-read error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      cts_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      cts_r <= write_en_s;
      if (write_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
      end
      case ({write_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
      if (multi_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign CTS            = cts_r;
  assign count          = count_r;
  assign empty          = empty_s;
  assign full           = full_s;
  assign err_multi_read = err_r;
  assign Data_out       = mem_r[rd_ptr_r];

endmodule
